// File: rtl/wimax_pkg.sv
// Shared constants and types for the WiMAX block bit interleaver.
package wimax_pkg;
  localparam int unsigned NCBPS = 192;
  localparam int unsigned NCPC  = 2;
  localparam int unsigned S     = (NCPC / 2 > 1) ? NCPC / 2 : 1;
  localparam int unsigned D     = 16;

  typedef logic [$clog2(NCBPS)-1:0] bit_idx_t;
endpackage

// File: rtl/interleaver_addr_gen.sv
// Combinational input-index to interleaved-address mapping (both 802.16 permutations).
module interleaver_addr_gen #(
  parameter int unsigned Ncbps = 192,
  parameter int unsigned Ncpc  = 2,
  parameter int unsigned s     = (Ncpc / 2 > 1) ? Ncpc / 2 : 1,
  parameter int unsigned d     = 16
) (
  input  logic [$clog2(Ncbps)-1:0] k,
  output logic [$clog2(Ncbps)-1:0] j
);
  localparam int unsigned W = $clog2(Ncbps);

  logic [31:0] kk;
  logic [31:0] m;
  logic [31:0] jj;

  always_comb begin
    kk = 32'(k);
    m  = (Ncbps / d) * (kk % d) + kk / d;
    jj = s * (m / s) + ((m + Ncbps - (d * m) / Ncbps) % s);
    j  = W'(jj);
  end
endmodule

// File: rtl/wimax_interleaver.sv
// Ping-pong block bit interleaver: permuted writes into one bank while the other streams out in order.
module wimax_interleaver
  import wimax_pkg::*;
#(
  parameter int unsigned Ncbps = NCBPS,
  parameter int unsigned Ncpc  = NCPC,
  parameter int unsigned s     = S,
  parameter int unsigned d     = D
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic                     data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(Ncbps)-1:0] data_out_index
);
  localparam int unsigned W    = $clog2(Ncbps);
  localparam logic [W-1:0] LAST = W'(Ncbps - 1);

  logic [Ncbps-1:0] bank [2];
  logic [1:0]       full;
  logic             wr_sel;
  logic             rd_sel;
  logic [W-1:0]     wr_cnt;
  logic [W-1:0]     rd_cnt;
  logic [W-1:0]     wr_addr;
  logic             wr_en;
  logic             rd_en;
  logic             wr_last;
  logic             rd_last;

  interleaver_addr_gen #(
    .Ncbps(Ncbps),
    .Ncpc (Ncpc),
    .s    (s),
    .d    (d)
  ) u_addr_gen (
    .k(wr_cnt),
    .j(wr_addr)
  );

  assign ready_out      = !full[wr_sel];
  assign valid_out      = full[rd_sel];
  assign data_out       = bank[rd_sel][rd_cnt];
  assign data_out_index = rd_cnt;

  assign wr_en   = valid_in && ready_out;
  assign rd_en   = valid_out && ready_in;
  assign wr_last = (wr_cnt == LAST);
  assign rd_last = (rd_cnt == LAST);

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      bank[0] <= '0;
      bank[1] <= '0;
      full    <= '0;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      if (wr_en) begin
        bank[wr_sel][wr_addr] <= data_in;
        wr_cnt <= wr_last ? '0 : wr_cnt + W'(1);
        if (wr_last) wr_sel <= ~wr_sel;
      end
      if (rd_en) begin
        rd_cnt <= rd_last ? '0 : rd_cnt + W'(1);
        if (rd_last) rd_sel <= ~rd_sel;
      end
      // A filling bank is never full and a draining bank always is, so these never target the same flag.
      if (wr_en && wr_last) full[wr_sel] <= 1'b1;
      if (rd_en && rd_last) full[rd_sel] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wimax_interleaver.sv
// Self-checking bench for wimax_interleaver: directed golden/edge cases plus randomized blocks vs a block model.
module tb_wimax_interleaver;
  import wimax_pkg::*;

  logic     clk = 1'b0;
  logic     resetN = 1'b1;
  logic     data_in = 1'b0;
  logic     valid_in = 1'b0;
  logic     ready_out;
  logic     data_out;
  logic     valid_out;
  logic     ready_in = 1'b0;
  bit_idx_t data_out_index;

  wimax_interleaver dut (
    .clk           (clk),
    .resetN        (resetN),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .data_out_index(data_out_index)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   exp_idx = 0;
  int   acc = 0;
  int   ri_mode = 0;
  logic exp_q[$];

  localparam logic [191:0] GOLD_IN  = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
  localparam logic [191:0] GOLD_OUT = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MSB-first vector -> vector whose bit [i] is element i in time.
  function automatic logic [191:0] msb_first(input logic [191:0] v);
    logic [191:0] r;
    for (int i = 0; i < 192; i++) r[i] = v[191 - i];
    return r;
  endfunction

  // Reference: out[j(k)] = in[k], j computed from the two-step 802.16 permutation.
  function automatic logic [191:0] model(input logic [191:0] kv);
    logic [191:0] o;
    int unsigned  m;
    int unsigned  j;
    o = '0;
    for (int unsigned k = 0; k < NCBPS; k++) begin
      m = (NCBPS / D) * (k % D) + k / D;
      j = S * (m / S) + ((m + NCBPS - (D * m) / NCBPS) % S);
      o[j] = kv[k];
    end
    return o;
  endfunction

  function automatic logic [191:0] rand_block();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_out(input logic [191:0] ov);
    for (int i = 0; i < 192; i++) exp_q.push_back(ov[i]);
  endtask

  task automatic tick(input logic vi, input logic di);
    logic e;
    valid_in = vi;
    data_in  = di;
    ready_in = (ri_mode == 2) ? 1'($urandom_range(0, 1)) : (ri_mode == 0);
    if (valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(valid_out), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(e));
        chk("data_out_index", 32'(data_out_index), 32'(exp_idx));
        exp_idx = (exp_idx + 1) % 192;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // gap: 0 = back to back, 1 = idle cycle before each bit, 2 = random idle cycles
  task automatic feed_bit(input logic d, input int gap);
    int n;
    n = 0;
    if (gap == 1) begin
      tick(1'b0, 1'b0);
      chk("wr_cnt_hold", 32'(dut.wr_cnt), 32'(acc % 192));
    end else if (gap == 2) begin
      while ($urandom_range(0, 1) == 1 && n < 4) begin
        tick(1'b0, 1'b0);
        n++;
      end
    end
    n = 0;
    while (!ready_out && n < 2000) begin
      tick(1'b0, 1'b0);
      n++;
    end
    if (!ready_out) begin
      chk("ready_out_timeout", 32'(ready_out), 32'(1));
    end else begin
      tick(1'b1, d);
      acc++;
    end
  endtask

  task automatic feed_block(input logic [191:0] kv, input logic [191:0] ov, input int gap);
    for (int k = 0; k < 192; k++) feed_bit(kv[k], gap);
    push_out(ov);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_out"}, 32'(valid_out), 32'(0));
    chk({tag, "_data_out"}, 32'(data_out), 32'(0));
    chk({tag, "_index"}, 32'(data_out_index), 32'(0));
    chk({tag, "_ready_out"}, 32'(ready_out), 32'(1));
  endtask

  initial begin
    logic [191:0] gin;
    logic [191:0] gout;
    logic [191:0] a;
    logic [191:0] b;
    logic [191:0] v;
    logic [191:0] ov;
    logic [191:0] kks;
    logic [191:0] iis;
    int           spot_k [3];
    int           spot_i [3];

    gin  = msb_first(GOLD_IN);
    gout = msb_first(GOLD_OUT);

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    resetN = 1'b0;
    tick(1'b0, 1'b0);

    // Golden block: valid_out rises right after the last accepted bit
    ri_mode = 0;
    for (int k = 0; k < 191; k++) feed_bit(gin[k], 0);
    chk("valid_before_last", 32'(valid_out), 32'(0));
    feed_bit(gin[191], 0);
    chk("valid_after_last", 32'(valid_out), 32'(1));
    push_out(gout);
    drain(400);

    // Continuous stream of 11 golden blocks
    for (int blk = 0; blk < 11; blk++) begin
      for (int k = 0; k < 192; k++) begin
        chk("ready_out_stream", 32'(ready_out), 32'(1));
        feed_bit(gin[k], 0);
      end
      push_out(gout);
    end
    drain(400);

    // Spot mapping: single 1 at input k lands at output index i
    spot_k = '{16, 1, 191};
    spot_i = '{1, 12, 191};
    for (int t = 0; t < 3; t++) begin
      kks = '0;
      iis = '0;
      kks[spot_k[t]] = 1'b1;
      iis[spot_i[t]] = 1'b1;
      feed_block(kks, iis, 0);
    end
    drain(400);

    // Backpressure: two blocks buffered with the mapper stalled
    ri_mode = 1;
    a = rand_block();
    b = rand_block();
    feed_block(a, model(a), 0);
    for (int k = 0; k < 191; k++) feed_bit(b[k], 0);
    chk("ready_before_384", 32'(ready_out), 32'(1));
    feed_bit(b[191], 0);
    push_out(model(b));
    chk("ready_after_384", 32'(ready_out), 32'(0));
    chk("valid_stalled", 32'(valid_out), 32'(1));
    tick(1'b0, 1'b0);
    chk("ready_still_low", 32'(ready_out), 32'(0));
    ri_mode = 0;
    for (int i = 0; i < 192; i++) tick(1'b0, 1'b0);
    chk("ready_restored", 32'(ready_out), 32'(1));
    drain(400);

    // Reset in the middle of a block while another block is streaming out
    a = rand_block();
    a[100] = 1'b1;
    feed_block(a, model(a), 0);
    b = rand_block();
    for (int k = 0; k < 100; k++) feed_bit(b[k], 0);
    chk("valid_before_reset", 32'(valid_out), 32'(1));
    valid_in = 1'b0;
    resetN = 1'b1;
    #2;
    check_reset_outputs("mid_reset_async");
    exp_q.delete();
    exp_idx = 0;
    acc = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset_held");
    resetN = 1'b0;
    tick(1'b0, 1'b0);
    v = rand_block();
    feed_block(v, model(v), 0);
    drain(400);

    // valid_in toggling every other cycle on the golden block
    feed_block(gin, gout, 1);
    drain(400);

    // Random valid/ready on random blocks
    ri_mode = 2;
    for (int blk = 0; blk < 4; blk++) begin
      v  = rand_block();
      ov = model(v);
      feed_block(v, ov, 2);
    end
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
